// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined array multiplier: row generation and
// configuration checking used by every stage.
package mult_pkg;

    localparam int MULT_MAX_WIDTH = 32;
    localparam int MULT_ROW_W     = 2 * MULT_MAX_WIDTH;

    // Row = (a_bit ? extended b : 0) << idx, reduced modulo 2^(2*width).
    function automatic logic [MULT_ROW_W-1:0] mult_row(
        input logic                      a_bit,
        input logic [MULT_MAX_WIDTH-1:0] b,
        input int                        idx,
        input logic                      is_signed,
        input int                        width
    );
        logic [MULT_ROW_W-1:0]     ext;
        logic [MULT_ROW_W-1:0]     mask;
        logic [MULT_MAX_WIDTH-1:0] bTop;
        mask = (MULT_ROW_W'(1) << (2 * width)) - MULT_ROW_W'(1);
        ext  = {{MULT_MAX_WIDTH{1'b0}}, b};
        bTop = b >> (width - 1);
        if (is_signed && bTop[0]) begin
            ext = ext | ~((MULT_ROW_W'(1) << width) - MULT_ROW_W'(1));
        end
        ext = ext & mask;
        if (a_bit) begin
            mult_row = (ext << idx) & mask;
        end else begin
            mult_row = '0;
        end
    endfunction

    function automatic bit mult_cfg_ok(input int width, input int rows);
        return (width >= 2) && (width <= MULT_MAX_WIDTH) &&
               (rows >= 1) && (rows <= width) && ((width % rows) == 0);
    endfunction

endpackage

// File: rtl/array_mult_stage.sv
// One registered pipeline stage: adds ROWS_PER_STAGE partial-product rows to
// the running sum and forwards operands, valid bit and signedness.
module array_mult_stage
    import mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 1,
    parameter int STAGE_IDX      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv_i,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    input  logic [2*WIDTH-1:0] sum_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               signed_o,
    output logic [2*WIDTH-1:0] sum_o
);

    logic               valid_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               signed_q;
    logic [2*WIDTH-1:0] sum_q;
    logic [2*WIDTH-1:0] sum_d;

    // The top row carries negative weight in two's complement, so it is subtracted.
    always_comb begin
        sum_d = sum_i;
        for (int r = 0; r < ROWS_PER_STAGE; r++) begin
            if (signed_i && (STAGE_IDX * ROWS_PER_STAGE + r == WIDTH - 1)) begin
                sum_d = sum_d - (2*WIDTH)'(mult_row(1'(a_i >> (STAGE_IDX * ROWS_PER_STAGE + r)),
                                                    MULT_MAX_WIDTH'(b_i),
                                                    STAGE_IDX * ROWS_PER_STAGE + r,
                                                    signed_i, WIDTH));
            end else begin
                sum_d = sum_d + (2*WIDTH)'(mult_row(1'(a_i >> (STAGE_IDX * ROWS_PER_STAGE + r)),
                                                    MULT_MAX_WIDTH'(b_i),
                                                    STAGE_IDX * ROWS_PER_STAGE + r,
                                                    signed_i, WIDTH));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            sum_q    <= '0;
        end else if (adv_i) begin
            valid_q  <= valid_i;
            a_q      <= a_i;
            b_q      <= b_i;
            signed_q <= signed_i;
            sum_q    <= sum_d;
        end
    end

    assign valid_o  = valid_q;
    assign a_o      = a_q;
    assign b_o      = b_q;
    assign signed_o = signed_q;
    assign sum_o    = sum_q;

endmodule

// File: rtl/pipelined_array_multiplier.sv
// Pipelined signed/unsigned array multiplier with valid/ready handshakes; the
// whole pipeline advances together and stalls when the output is blocked.
module pipelined_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int S = WIDTH / ROWS_PER_STAGE;

    if (!mult_cfg_ok(WIDTH, ROWS_PER_STAGE)) begin : gCfgCheck
        $error("pipelined_array_multiplier: WIDTH must be 2..%0d and a multiple of ROWS_PER_STAGE",
               MULT_MAX_WIDTH);
    end

    logic               adv;
    logic               validChain  [S+1];
    logic [WIDTH-1:0]   aChain      [S+1];
    logic [WIDTH-1:0]   bChain      [S+1];
    logic               signedChain [S+1];
    logic [2*WIDTH-1:0] sumChain    [S+1];

    // A single global enable keeps in_ready free of any in_valid dependency.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign validChain[0]  = in_valid && adv;
    assign aChain[0]      = in_a;
    assign bChain[0]      = in_b;
    assign signedChain[0] = in_signed;
    assign sumChain[0]    = '0;

    for (genvar k = 0; k < S; k++) begin : gStage
        array_mult_stage #(
            .WIDTH          (WIDTH),
            .ROWS_PER_STAGE (ROWS_PER_STAGE),
            .STAGE_IDX      (k)
        ) uStage (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv_i    (adv),
            .valid_i  (validChain[k]),
            .a_i      (aChain[k]),
            .b_i      (bChain[k]),
            .signed_i (signedChain[k]),
            .sum_i    (sumChain[k]),
            .valid_o  (validChain[k+1]),
            .a_o      (aChain[k+1]),
            .b_o      (bChain[k+1]),
            .signed_o (signedChain[k+1]),
            .sum_o    (sumChain[k+1])
        );
    end

    assign out_valid = validChain[S];
    assign out_p     = sumChain[S];

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Self-checking bench: runs the same directed/random suite against an 8x8
// (one row per stage) and a 16x16 (four rows per stage) instance.
module tb_pipelined_array_multiplier;

    logic        clk = 1'b0;
    logic        rstN;
    logic        tbValid;
    logic [15:0] tbA;
    logic [15:0] tbB;
    logic        tbSigned;
    logic        tbOutReady;
    bit          sel;

    logic        ir8, ov8, ir16, ov16;
    logic [15:0] p8;
    logic [31:0] p16;

    logic        obsReady;
    logic        obsValid;
    logic [63:0] obsP;

    int          compared   = 0;
    int          mismatched = 0;
    int          cycleNum   = 0;
    int          takeCount  = 0;
    int          firstTake  = 0;
    int          lastTake   = 0;
    logic [63:0] expQ [$];

    always #5 clk = ~clk;

    pipelined_array_multiplier #(.WIDTH(8), .ROWS_PER_STAGE(1)) dut8 (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (tbValid && !sel),
        .in_ready  (ir8),
        .in_a      (tbA[7:0]),
        .in_b      (tbB[7:0]),
        .in_signed (tbSigned),
        .out_valid (ov8),
        .out_ready (sel ? 1'b1 : tbOutReady),
        .out_p     (p8)
    );

    pipelined_array_multiplier #(.WIDTH(16), .ROWS_PER_STAGE(4)) dut16 (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (tbValid && sel),
        .in_ready  (ir16),
        .in_a      (tbA),
        .in_b      (tbB),
        .in_signed (tbSigned),
        .out_valid (ov16),
        .out_ready (sel ? tbOutReady : 1'b1),
        .out_p     (p16)
    );

    assign obsReady = sel ? ir16 : ir8;
    assign obsValid = sel ? ov16 : ov8;
    assign obsP     = sel ? {32'b0, p16} : {48'b0, p8};

    function automatic int curW();
        return sel ? 16 : 8;
    endfunction

    function automatic int curS();
        return sel ? 4 : 8;
    endfunction

    // Reference: interpret operands as integers and multiply, then wrap.
    function automatic logic [63:0] refProd(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
        longint sa, sb, prod;
        logic [15:0] aTop, bTop;
        sa   = longint'({48'b0, a});
        sb   = longint'({48'b0, b});
        aTop = a >> (w - 1);
        bTop = b >> (w - 1);
        if (s && aTop[0]) sa = sa - (longint'(1) << w);
        if (s && bTop[0]) sb = sb - (longint'(1) << w);
        prod = sa * sb;
        return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [15:0] randOp();
        return 16'($urandom) & 16'((32'd1 << curW()) - 32'd1);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s (W=%0d): observed=0x%0h expected=0x%0h", tag, curW(), obs, exp);
        end
    endtask

    // Drive one cycle: score any output handshake and record any accepted input.
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic ordy);
        logic [63:0] exp;
        tbValid    = v;
        tbA        = a;
        tbB        = b;
        tbSigned   = s;
        tbOutReady = ordy;
        #1;
        if (obsValid && tbOutReady) begin
            if (expQ.size() > 0) exp = expQ.pop_front();
            else                 exp = 64'hDEAD_BEEF_DEAD_BEEF;
            checkOutput("product", obsP, exp);
            takeCount++;
            if (takeCount == 1) firstTake = cycleNum;
            lastTake = cycleNum;
        end
        if (v && obsReady) expQ.push_back(refProd(curW(), a, b, s));
        cycleNum++;
        @(negedge clk);
    endtask

    task automatic runDirected(input logic [15:0] a, input logic [15:0] b, input logic s,
                               input logic [63:0] want, input string tag);
        int lat;
        applyStimulus(1'b1, a, b, s, 1'b1);
        lat = 1;
        while (!obsValid && lat < 40) begin
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            lat++;
        end
        if (!obsValid) lat = 999;
        checkOutput({tag, "_latency"}, 64'(lat), 64'(curS()));
        checkOutput(tag, obsP, want);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic runSuite();
        logic [15:0] dA [5];
        logic [15:0] dB [5];
        logic        dS [5];
        logic [63:0] dW [5];
        logic [63:0] held;
        logic [15:0] ra, rb;
        logic        rs;
        int          n, seen;

        $display("[TB] suite WIDTH=%0d stages=%0d", curW(), curS());
        expQ.delete();
        tbValid    = 1'b0;
        tbOutReady = 1'b0;
        rstN       = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(obsValid), 64'd0);
        checkOutput("reset_out_p", obsP, 64'd0);
        checkOutput("reset_in_ready", 64'(obsReady), 64'd1);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        dS = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        if (!sel) begin
            dA = '{16'h00FF, 16'h0000, 16'h0080, 16'h00FF, 16'h007F};
            dB = '{16'h00FF, 16'h00AD, 16'h0080, 16'h0001, 16'h0080};
            dW = '{64'hFE01, 64'h0000, 64'h4000, 64'hFFFF, 64'hC080};
        end else begin
            dA = '{16'hFFFF, 16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
            dB = '{16'hFFFF, 16'h00AD, 16'h8000, 16'h0001, 16'h8000};
            dW = '{64'hFFFE_0001, 64'h0, 64'h4000_0000, 64'hFFFF_FFFF, 64'hC000_8000};
        end
        for (int i = 0; i < 5; i++) begin
            runDirected(dA[i], dB[i], dS[i], dW[i], $sformatf("directed%0d", i));
        end

        // Back-to-back random stream with no output stalls.
        takeCount = 0;
        tbOutReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            checkOutput("stream_in_ready", 64'(obsReady), 64'd1);
            applyStimulus(1'b1, randOp(), randOp(), 1'($urandom), 1'b1);
        end
        n = 0;
        while (expQ.size() > 0 && n < 60) begin
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("stream_drained", 64'(expQ.size()), 64'd0);
        checkOutput("stream_count", 64'(takeCount), 64'd100);
        checkOutput("stream_span", 64'(lastTake - firstTake + 1), 64'd100);

        // Fill the pipeline, then block the output for five cycles.
        n = 0;
        while (!obsValid && n < 40) begin
            applyStimulus(1'b1, randOp(), randOp(), 1'($urandom), 1'b1);
            n++;
        end
        checkOutput("bp_fill", 64'(obsValid), 64'd1);
        held = obsP;
        for (int c = 0; c < 5; c++) begin
            ra = randOp();
            rb = randOp();
            rs = 1'($urandom);
            tbValid    = 1'b1;
            tbOutReady = 1'b0;
            #1;
            checkOutput("bp_in_ready", 64'(obsReady), 64'd0);
            checkOutput("bp_out_valid", 64'(obsValid), 64'd1);
            checkOutput("bp_hold", obsP, held);
            applyStimulus(1'b1, ra, rb, rs, 1'b0);
        end
        n = 0;
        while (expQ.size() > 0 && n < 60) begin
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("bp_drained", 64'(expQ.size()), 64'd0);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Reset with four transactions in flight.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, randOp() | 16'h3, randOp() | 16'h3, 1'b0, 1'b1);
        end
        tbValid = 1'b0;
        rstN    = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(obsValid), 64'd0);
        checkOutput("midrst_out_p", obsP, 64'd0);
        expQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (obsValid) seen++;
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        end
        checkOutput("midrst_stale", 64'(seen), 64'd0);
    endtask

    initial begin
        rstN       = 1'b0;
        tbValid    = 1'b0;
        tbA        = '0;
        tbB        = '0;
        tbSigned   = 1'b0;
        tbOutReady = 1'b0;
        sel        = 1'b0;
        @(negedge clk);
        runSuite();
        sel = 1'b1;
        runSuite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
